// File: rtl/n_bit_pkg.sv
// rtl/n_bit_pkg.sv - shared state encoding and width helper for the restoring divider
// Purpose : FSM state type used by n_bit_div and the counter-width function.
// Contents: state_t (IDLE, CALC, DONE), clog2(value) = ceil(log2(value)).
package n_bit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int v;
      int res;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: compare and conditionally subtract
// Purpose : given the already-shifted partial remainder, produce the next
//           remainder and the quotient bit for this step.
// Ports   : rem      [BIT_DEPTH:0]   shifted partial remainder
//           divisor  [BIT_DEPTH-1:0] divisor
//           rem_next [BIT_DEPTH:0]   remainder after the conditional subtract
//           q_bit                    1 when the divisor was subtracted
module div_step #(
   parameter int BIT_DEPTH = 32
) (
   input  logic [BIT_DEPTH:0]   rem,
   input  logic [BIT_DEPTH-1:0] divisor,
   output logic [BIT_DEPTH:0]   rem_next,
   output logic                 q_bit
);

   logic [BIT_DEPTH:0] divisor_ext;

   always_comb begin
      divisor_ext = {1'b0, divisor};
      q_bit       = (rem >= divisor_ext);
      rem_next    = q_bit ? (rem - divisor_ext) : rem;
   end

endmodule

// File: rtl/n_bit_div.sv
// rtl/n_bit_div.sv - sequential unsigned restoring divider, one quotient bit per clock
// Purpose : q = a / b, r = a % b after BIT_DEPTH cycles; b == 0 gives
//           q = all ones, r = a, div_by_zero = 1 one cycle after acceptance.
// Ports   : clk, rst (sync, active-high), start, a, b  -> inputs
//           busy (state CALC), done (state DONE, one-cycle pulse),
//           q, r, div_by_zero (registered result)      -> outputs
module n_bit_div #(
   parameter int BIT_DEPTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BIT_DEPTH-1:0] a,
   input  logic [BIT_DEPTH-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_DEPTH-1:0] q,
   output logic [BIT_DEPTH-1:0] r,
   output logic                 div_by_zero
);

   import n_bit_pkg::*;

   localparam int CNT_W = clog2(BIT_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIT_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_t               state;
   state_t               state_nxt;
   logic                 accept;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_DEPTH-1:0] dvd;      // dividend, shifts out MSB first and collects quotient bits
   logic [BIT_DEPTH-1:0] dvs;
   logic [BIT_DEPTH:0]   rem;
   logic [BIT_DEPTH:0]   rem_shift;
   logic [BIT_DEPTH:0]   rem_next;
   logic                 q_bit;

   // rem[BIT_DEPTH] is always zero here, so the shift drops nothing.
   assign rem_shift = (rem << 1) | {{BIT_DEPTH{1'b0}}, dvd[BIT_DEPTH-1]};

   div_step #(
      .BIT_DEPTH (BIT_DEPTH)
   ) u_div_step (
      .rem      (rem_shift),
      .divisor  (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (b == '0) ? DONE : CALC;
            end else begin
               state_nxt = IDLE;
            end
         end
         CALC: begin
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dvd <= a;
         dvs <= b;
         rem <= '0;
         cnt <= CNT_LOAD;
         if (b == '0) begin
            q           <= '1;
            r           <= a;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         rem <= rem_next;
         dvd <= {dvd[BIT_DEPTH-2:0], q_bit};
         cnt <= cnt - CNT_LAST;
         // Results are published only on the final step so q/r never show partial values.
         if (cnt == CNT_LAST) begin
            q           <= {dvd[BIT_DEPTH-2:0], q_bit};
            r           <= rem_next[BIT_DEPTH-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

endmodule

// File: tb/tb_n_bit_div.sv
// tb/tb_n_bit_div.sv - self-checking bench for n_bit_div at BIT_DEPTH 8 and 32
module tb_n_bit_div;

   logic        clk;
   logic        rst;
   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        busy8;
   logic        done8;
   logic [7:0]  q8;
   logic [7:0]  r8;
   logic        dbz8;
   logic        start32;
   logic [31:0] a32;
   logic [31:0] b32;
   logic        busy32;
   logic        done32;
   logic [31:0] q32;
   logic [31:0] r32;
   logic        dbz32;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_q;
   logic [31:0] last_r;

   n_bit_div #(.BIT_DEPTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .q(q8), .r(r8), .div_by_zero(dbz8)
   );

   n_bit_div #(.BIT_DEPTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .q(q32), .r(r32), .div_by_zero(dbz32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_q(input bit w);
      return w ? q32 : {24'b0, q8};
   endfunction
   function automatic logic [31:0] get_r(input bit w);
      return w ? r32 : {24'b0, r8};
   endfunction
   function automatic logic get_done(input bit w);
      return w ? done32 : done8;
   endfunction
   function automatic logic get_busy(input bit w);
      return w ? busy32 : busy8;
   endfunction
   function automatic logic get_dbz(input bit w);
      return w ? dbz32 : dbz8;
   endfunction

   task automatic set_in(input bit w, input logic [31:0] ta, input logic [31:0] tbv, input logic st);
      if (w) begin
         a32 = ta; b32 = tbv; start32 = st;
      end else begin
         a8 = ta[7:0]; b8 = tbv[7:0]; start8 = st;
      end
   endtask

   // Issues one division and checks it against plain / and % arithmetic.
   // glitch_at >= 0 pulses start with a=1,b=1 at that cycle of the run.
   task automatic run_op(input bit w, input logic [31:0] ta, input logic [31:0] tbv,
                         input int glitch_at, input string tag);
      int          width;
      logic [31:0] mask, ea, eb, eq, er, qprev;
      logic        ed;
      int          lat, busy_cnt;
      bit          hold_ok;
      width = w ? 32 : 8;
      mask  = w ? 32'hFFFF_FFFF : 32'h0000_00FF;
      ea    = ta & mask;
      eb    = tbv & mask;
      if (eb == 0) begin
         eq = mask; er = ea; ed = 1'b1;
      end else begin
         eq = ea / eb; er = ea % eb; ed = 1'b0;
      end
      qprev = get_q(w);
      set_in(w, ta, tbv, 1'b1);
      @(posedge clk); #1;
      lat = 0; busy_cnt = 0; hold_ok = 1'b1;
      while (get_done(w) !== 1'b1 && lat < width + 4) begin
         if (lat == glitch_at) set_in(w, 32'd1, 32'd1, 1'b1);
         else                  set_in(w, $urandom, $urandom, 1'b0);
         if (get_busy(w) === 1'b1) busy_cnt++;
         if (get_q(w) !== qprev) hold_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      set_in(w, $urandom, $urandom, 1'b0);
      check({tag, "_latency"}, lat, (eb == 0) ? 0 : width);
      check({tag, "_busy_cycles"}, busy_cnt, (eb == 0) ? 0 : width);
      check({tag, "_q_held"}, hold_ok, 1);
      check({tag, "_q"}, get_q(w), eq);
      check({tag, "_r"}, get_r(w), er);
      check({tag, "_dbz"}, get_dbz(w), ed);
      if (eb != 0) begin
         check({tag, "_identity"}, {32'b0, get_q(w)} * {32'b0, eb} + {32'b0, get_r(w)}, {32'b0, ea});
         check({tag, "_r_lt_b"}, get_r(w) < eb, 1);
      end
      last_q = get_q(w);
      last_r = get_r(w);
   endtask

   task automatic idle_check(input bit w, input string tag);
      set_in(w, $urandom, $urandom, 1'b0);
      @(posedge clk); #1;
      check({tag, "_done_single"}, get_done(w), 0);
      check({tag, "_idle_busy"}, get_busy(w), 0);
   endtask

   initial begin
      bit          seen;
      logic [31:0] ra, rb;
      rst = 1'b1;
      set_in(0, 0, 0, 1'b0);
      set_in(1, 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_q8", q8, 0);
      check("rst_r8", r8, 0);
      check("rst_dbz8", dbz8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_q32", q32, 0);
      check("rst_busy32", busy32, 0);
      check("rst_done32", done32, 0);
      rst = 1'b0;

      run_op(0, 100, 7, -1, "d100_7");
      check("d100_7_q_const", last_q, 14);
      check("d100_7_r_const", last_r, 2);
      idle_check(0, "d100_7");

      run_op(0, 255, 1, -1, "d255_1");
      check("d255_1_q_const", last_q, 255);
      check("d255_1_r_const", last_r, 0);
      run_op(0, 3, 200, -1, "b2b_3_200");
      check("b2b_q_const", last_q, 0);
      check("b2b_r_const", last_r, 3);
      idle_check(0, "b2b");

      run_op(0, 5, 0, -1, "dz5");
      check("dz5_q_const", last_q, 255);
      check("dz5_r_const", last_r, 5);
      idle_check(0, "dz5");

      set_in(0, 200, 9, 1'b1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_q", q8, 0);
      check("abort_r", r8, 0);
      check("abort_dbz", dbz8, 0);
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8 !== 1'b0) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      run_op(0, 200, 9, -1, "after_abort");
      check("after_abort_q_const", last_q, 22);
      check("after_abort_r_const", last_r, 2);
      idle_check(0, "after_abort");

      run_op(0, 77, 5, 3, "busy_start");
      check("busy_start_q_const", last_q, 15);
      check("busy_start_r_const", last_r, 2);
      idle_check(0, "busy_start");

      run_op(0, 0, 13, -1, "zero_a");
      idle_check(0, "zero_a");

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = (i % 7 == 3) ? 32'd0 : 32'($urandom_range(1, 255));
         run_op(0, ra, rb, -1, "rand8");
         if ($urandom_range(0, 1) == 1) idle_check(0, "rand8");
      end
      idle_check(0, "rand8_end");

      run_op(1, 32'hFFFF_FFFF, 1, -1, "max32");
      idle_check(1, "max32");
      run_op(1, 32'h1234_5678, 0, -1, "dz32");
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (i % 9 == 4) rb = 32'd0;
         else if (rb == 0) rb = 32'd1;
         run_op(1, ra, rb, -1, "rand32");
         if ($urandom_range(0, 1) == 1) idle_check(1, "rand32");
      end
      idle_check(1, "rand32_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
